seq_divider: RTL and testbench

//   Multicycle 32-bit integer divider. The CPU consumes it for ALU ops with r13[4] set.
//   It computes the signed or unsigned quotient or remainder of a/b with a restoring algorithm.

---
 rtl/seq_divider.sv | 132 +++++++++++++
 tb/tb_seq_divider.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multicycle restoring divider: signed/unsigned quotient or remainder with a go/available handshake.
// Optional SEQ_DIVIDER_RADIX4_EN retires two quotient bits per RUN edge instead of one.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             go,
   input  logic             divs,
   input  logic             remainder,
   output logic [WIDTH-1:0] c,
   output logic             is_zero,
   output logic             is_negative,
   output logic             available
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   localparam int CW = $clog2(WIDTH);
`ifdef SEQ_DIVIDER_RADIX4_EN
   localparam int STEPS = WIDTH / 2;
`else
   localparam int STEPS = WIDTH;
`endif
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   state_t           state;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] div_q;
   logic [CW-1:0]    count;
   logic             neg_quo;
   logic             neg_rem;
   logic             div_zero;
   logic             want_rem;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] next_rem;
   logic [WIDTH-1:0] next_quo;
   logic [WIDTH-1:0] fix_result;

   // One restoring step: shift {rem,quo} left, keep the trial difference when it is non-negative.
   // The shifted remainder needs WIDTH+1 bits; the kept difference always fits back into WIDTH.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] d);
      logic [WIDTH:0] shifted;
      shifted = {r, q[WIDTH-1]};
      if (shifted >= {1'b0, d})
         return {shifted[WIDTH-1:0] - d, q[WIDTH-2:0], 1'b1};
      else
         return {shifted[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
   endfunction

   // Operand magnitudes; the most negative value maps onto its unsigned bit pattern.
   always_comb begin
      a_mag = (divs && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_mag = (divs && b[WIDTH-1]) ? (~b + 1'b1) : b;
   end

   always_comb begin
      {step_rem, step_quo} = div_step(rem_q, quo_q, div_q);
`ifdef SEQ_DIVIDER_RADIX4_EN
      {next_rem, next_quo} = div_step(step_rem, step_quo, div_q);
`else
      {next_rem, next_quo} = {step_rem, step_quo};
`endif
   end

   // Divide by zero leaves quo all ones and rem = |a|, so only the quotient sign fix is bypassed.
   always_comb begin
      if (want_rem)
         fix_result = neg_rem ? (~rem_q + 1'b1) : rem_q;
      else if (div_zero)
         fix_result = '1;
      else
         fix_result = neg_quo ? (~quo_q + 1'b1) : quo_q;
   end

   // A go in any state recaptures operands and abandons whatever was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         div_q       <= '0;
         count       <= '0;
         neg_quo     <= 1'b0;
         neg_rem     <= 1'b0;
         div_zero    <= 1'b0;
         want_rem    <= 1'b0;
         c           <= '0;
         is_zero     <= 1'b0;
         is_negative <= 1'b0;
      end else if (go) begin
         state    <= RUN;
         rem_q    <= '0;
         quo_q    <= a_mag;
         div_q    <= b_mag;
         count    <= '0;
         neg_quo  <= divs & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_rem  <= divs & a[WIDTH-1];
         div_zero <= (b == '0);
         want_rem <= remainder;
      end else begin
         case (state)
            RUN: begin
               rem_q <= next_rem;
               quo_q <= next_quo;
               count <= count + 1'b1;
               if (count == LAST)
                  state <= FIX;
            end
            FIX: begin
               c           <= fix_result;
               is_zero     <= (fix_result == '0);
               is_negative <= fix_result[WIDTH-1];
               state       <= DONE;
            end
            default: state <= state;
         endcase
      end
   end

   assign available = (state == DONE) && !go;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized operands
// checked against a plain-arithmetic reference model.
module tb_seq_divider;

   localparam int W = 32;
`ifdef SEQ_DIVIDER_RADIX4_EN
   localparam int LAT = W / 2 + 1;
`else
   localparam int LAT = W + 1;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         go = 1'b0;
   logic         divs = 1'b0;
   logic         remainder = 1'b0;
   logic [W-1:0] c;
   logic         is_zero;
   logic         is_negative;
   logic         available;

   int vectors = 0;
   int miscompares = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .go(go), .divs(divs),
      .remainder(remainder), .c(c), .is_zero(is_zero),
      .is_negative(is_negative), .available(available)
   );

   always #5 clk = ~clk;

   // Reference: integer division truncating toward zero, with the divide-by-zero convention.
   function automatic logic [W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sgn, input logic want_rem);
      longint sx, sy, r;
      if (y == '0) return want_rem ? x : '1;
      if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         r  = want_rem ? (sx % sy) : (sx / sy);
         return r[W-1:0];
      end
      return want_rem ? (x % y) : (x / y);
   endfunction

   // Launch one operation; reports what available showed while go was high.
   task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic sgn, input logic want_rem,
                                output logic avail_in_go);
      @(negedge clk);
      a = x; b = y; divs = sgn; remainder = want_rem; go = 1'b1;
      #1 avail_in_go = available;
      @(negedge clk);
      go = 1'b0;
      a = $urandom; b = $urandom; divs = $urandom; remainder = $urandom;
   endtask

   // Bounded wait; cycles counts edges after the go edge until available is seen.
   task automatic wait_done(output int cycles);
      cycles = 0;
      #1;
      while (available !== 1'b1 && cycles < 200) begin
         @(negedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({c, is_zero, is_negative, available} !== {{W{1'b0}}, 3'b000}) begin
         miscompares++;
         $display("[TB] FAIL reset_state: c=%h z=%b n=%b avail=%b, required all zero",
                  c, is_zero, is_negative, available);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic sgn, input logic want_rem);
      logic         ag;
      int           cyc;
      logic [W-1:0] exp;
      exp = ref_div(x, y, sgn, want_rem);
      applyStimulus(x, y, sgn, want_rem, ag);
      wait_done(cyc);
      vectors++;
      if (cyc != LAT) begin
         miscompares++;
         $display("[TB] FAIL %s latency: got %0d cycles, required %0d", name, cyc, LAT);
      end
      vectors++;
      if (c !== exp || is_zero !== (exp == '0) || is_negative !== exp[W-1]) begin
         miscompares++;
         $display("[TB] FAIL %s result: c=%h z=%b n=%b, required c=%h z=%b n=%b",
                  name, c, is_zero, is_negative, exp, (exp == '0), exp[W-1]);
      end
   endtask

   task automatic test_directed();
      run_and_check("unsigned_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
      vectors++;
      if (c !== 32'd14) begin
         miscompares++;
         $display("[TB] FAIL unsigned_const: c=%h, required 0000000e", c);
      end
      run_and_check("signed_rem", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1);
      vectors++;
      if (c !== 32'hFFFFFFFE || is_negative !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL signed_rem_const: c=%h n=%b, required fffffffe n=1", c, is_negative);
      end
      run_and_check("signed_quo", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0);
      run_and_check("unsigned_big", 32'hFFFFFFF0, 32'd3, 1'b0, 1'b0);
   endtask

   task automatic test_div_zero();
      run_and_check("dz_quo", 32'h1234, 32'd0, 1'b0, 1'b0);
      vectors++;
      if (c !== 32'hFFFFFFFF) begin
         miscompares++;
         $display("[TB] FAIL dz_quo_const: c=%h, required ffffffff", c);
      end
      run_and_check("dz_rem", 32'h1234, 32'd0, 1'b0, 1'b1);
      vectors++;
      if (c !== 32'h1234 || is_zero !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL dz_rem_const: c=%h z=%b, required 00001234 z=0", c, is_zero);
      end
      run_and_check("dz_signed_quo", 32'h80000005, 32'd0, 1'b1, 1'b0);
      run_and_check("dz_signed_rem", 32'hFFFFFF9C, 32'd0, 1'b1, 1'b1);
   endtask

   task automatic test_overflow();
      run_and_check("ovf_quo", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
      vectors++;
      if (c !== 32'h80000000) begin
         miscompares++;
         $display("[TB] FAIL ovf_quo_const: c=%h, required 80000000", c);
      end
      run_and_check("ovf_rem", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
      vectors++;
      if (c !== 32'h0 || is_zero !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL ovf_rem_const: c=%h z=%b, required 00000000 z=1", c, is_zero);
      end
      run_and_check("minint_div_2", 32'h80000000, 32'd2, 1'b1, 1'b0);
      run_and_check("minint_unsigned", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [W-1:0] x, y;
      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         case ($urandom_range(0, 4))
            0: y = $urandom_range(1, 15);
            1: y = 32'hFFFFFFFF - $urandom_range(0, 15);
            2: y = '0;
            default: y = $urandom;
         endcase
         if (i % 8 == 0) x = 32'h80000000;
         run_and_check($sformatf("rand%0d", i), x, y, 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      logic ag;
      int   cyc;
      run_and_check("b2b_first", 32'd100, 32'd7, 1'b0, 1'b0);
      applyStimulus(32'd1000, 32'd9, 1'b0, 1'b1, ag);
      vectors++;
      if (ag !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_avail_in_go: available=%b, required 0", ag);
      end
      #1;
      vectors++;
      if (c !== 32'd14 || available !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_hold: c=%h avail=%b, required 0000000e avail=0", c, available);
      end
      wait_done(cyc);
      vectors++;
      if (cyc != LAT || c !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL b2b_second: cycles=%0d c=%h, required %0d c=00000001", cyc, c, LAT);
      end
   endtask

   task automatic test_restart_mid_run();
      logic ag;
      int   cyc;
      applyStimulus(32'd5000, 32'd3, 1'b0, 1'b0, ag);
      repeat (5) @(negedge clk);
      applyStimulus(32'hFFFFFF00, 32'd16, 1'b1, 1'b0, ag);
      wait_done(cyc);
      vectors++;
      if (cyc != LAT || c !== 32'hFFFFFFF0) begin
         miscompares++;
         $display("[TB] FAIL restart: cycles=%0d c=%h, required %0d c=fffffff0", cyc, c, LAT);
      end
   endtask

   task automatic test_reset_mid_run();
      logic ag;
      int   seen;
      applyStimulus(32'd77, 32'd5, 1'b0, 1'b0, ag);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if (available !== 1'b0 || c !== '0 || is_zero !== 1'b0 || is_negative !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_run: c=%h z=%b n=%b avail=%b, required all zero",
                  c, is_zero, is_negative, available);
      end
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < LAT + 10; i++) begin
         @(negedge clk);
         #1;
         if (available === 1'b1) seen++;
      end
      vectors++;
      if (seen != 0 || c !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_no_result: available cycles=%0d c=%h, required 0 and 00000000",
                  seen, c);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_overflow();
      test_back_to_back();
      test_restart_mid_run();
      run_and_check("pre_reset_op", 32'd99, 32'd4, 1'b0, 1'b0);
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
